// File: rtl/mul_mdc_tcdm_arbiter.sv
// Round-robin merge of MP TCDM master ports onto one bank port, with an in-order
// index FIFO that routes responses back. Define MUL_MDC_TCDM_ARB_PERF_EN to add perf counters.
module mul_mdc_tcdm_arbiter #(
  parameter int MP         = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [MP-1:0]        tcdm_req,
  output logic [MP-1:0]        tcdm_gnt,
  input  logic [MP-1:0][31:0]  tcdm_add,
  input  logic [MP-1:0]        tcdm_wen,
  input  logic [MP-1:0][3:0]   tcdm_be,
  input  logic [MP-1:0][31:0]  tcdm_data,
  output logic [MP-1:0][31:0]  tcdm_r_data,
  output logic [MP-1:0]        tcdm_r_valid,
  output logic                 mem_req,
  input  logic                 mem_gnt,
  output logic [31:0]          mem_add,
  output logic                 mem_wen,
  output logic [3:0]           mem_be,
  output logic [31:0]          mem_data,
  input  logic [31:0]          mem_r_data,
  input  logic                 mem_r_valid,
  output logic                 err_o,
  output logic [31:0]          perf_gnt_o,
  output logic [31:0]          perf_stall_o
);

  localparam int RRW = $clog2(MP);
  localparam int PW  = $clog2(FIFO_DEPTH);

  logic [RRW-1:0] rr_q, rr_d;
  logic [RRW-1:0] w_s;
  logic           any_s;
  logic           full_s;
  logic           hs_s;
  logic           pop_s;
  logic [PW:0]    count_q, count_d;
  logic [PW-1:0]  wptr_q, wptr_d;
  logic [PW-1:0]  rptr_q, rptr_d;
  logic           err_q, err_d;
  logic [RRW-1:0] fifo_q [FIFO_DEPTH];

  assign any_s   = |tcdm_req;
  assign full_s  = (count_q == (PW+1)'(FIFO_DEPTH));
  assign mem_req = rst_ni & any_s & ~full_s;
  assign hs_s    = mem_req & mem_gnt;
  assign pop_s   = rst_ni & mem_r_valid & (count_q != '0);
  assign err_o   = rst_ni & err_q;

  // Winner search: first requester at or after rr_q, wrapping modulo MP.
  always_comb begin
    int unsigned idx;
    logic        found;
    w_s   = '0;
    found = 1'b0;
    for (int i = 0; i < MP; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= MP) begin
        idx = idx - MP;
      end else begin
        idx = idx;
      end
      if (!found && tcdm_req[idx]) begin
        w_s   = RRW'(idx);
        found = 1'b1;
      end else begin
        found = found;
      end
    end
  end

  // Bank payload mux and per-port grant / response routing.
  always_comb begin
    mem_add      = 32'h0;
    mem_wen      = 1'b0;
    mem_be       = 4'h0;
    mem_data     = 32'h0;
    tcdm_gnt     = '0;
    tcdm_r_valid = '0;
    tcdm_r_data  = '0;
    if (rst_ni && any_s) begin
      mem_add  = tcdm_add[w_s];
      mem_wen  = tcdm_wen[w_s];
      mem_be   = tcdm_be[w_s];
      mem_data = tcdm_data[w_s];
    end else begin
      mem_add  = 32'h0;
    end
    for (int i = 0; i < MP; i++) begin
      tcdm_gnt[i]     = hs_s && (w_s == RRW'(i));
      tcdm_r_valid[i] = pop_s && (fifo_q[rptr_q] == RRW'(i));
      tcdm_r_data[i]  = rst_ni ? mem_r_data : 32'h0;
    end
  end

  // Next-state for round-robin pointer, FIFO bookkeeping and the sticky error.
  always_comb begin
    rr_d    = rr_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    err_d   = err_q | (mem_r_valid & (count_q == '0));
    if (hs_s) begin
      rr_d   = (w_s == RRW'(MP - 1)) ? '0 : w_s + 1'b1;
      wptr_d = wptr_q + 1'b1;
    end else begin
      rr_d   = rr_q;
    end
    if (pop_s) begin
      rptr_d = rptr_q + 1'b1;
    end else begin
      rptr_d = rptr_q;
    end
    case ({hs_s, pop_s})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_q    <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      rr_q    <= rr_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Index storage; validity is tracked by count_q so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (rst_ni && hs_s) begin
      fifo_q[wptr_q] <= w_s;
    end
  end

`ifdef MUL_MDC_TCDM_ARB_PERF_EN
  logic [31:0] perf_gnt_q;
  logic [31:0] perf_stall_q;

  // Handshake and stall counters, wrapping naturally at 2^32.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      perf_gnt_q   <= 32'h0;
      perf_stall_q <= 32'h0;
    end else begin
      if (hs_s) begin
        perf_gnt_q <= perf_gnt_q + 32'h1;
      end
      if (any_s && !hs_s) begin
        perf_stall_q <= perf_stall_q + 32'h1;
      end
    end
  end

  assign perf_gnt_o   = rst_ni ? perf_gnt_q   : 32'h0;
  assign perf_stall_o = rst_ni ? perf_stall_q : 32'h0;
`else
  assign perf_gnt_o   = 32'h0;
  assign perf_stall_o = 32'h0;
`endif

endmodule

// File: tb/tb_mul_mdc_tcdm_arbiter.sv
// Randomized bench for mul_mdc_tcdm_arbiter against a queue-based reference model.
module tb_mul_mdc_tcdm_arbiter;
  localparam int MP = 4;
  localparam int FD = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [MP-1:0]       tcdm_req;
  logic [MP-1:0]       tcdm_gnt;
  logic [MP-1:0][31:0] tcdm_add;
  logic [MP-1:0]       tcdm_wen;
  logic [MP-1:0][3:0]  tcdm_be;
  logic [MP-1:0][31:0] tcdm_data;
  logic [MP-1:0][31:0] tcdm_r_data;
  logic [MP-1:0]       tcdm_r_valid;
  logic                mem_req, mem_gnt, mem_wen, mem_r_valid, err_o;
  logic [31:0]         mem_add, mem_data, mem_r_data, perf_gnt_o, perf_stall_o;
  logic [3:0]          mem_be;

  always #5 clk = ~clk;

  mul_mdc_tcdm_arbiter #(.MP(MP), .FIFO_DEPTH(FD)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .tcdm_req(tcdm_req), .tcdm_gnt(tcdm_gnt), .tcdm_add(tcdm_add), .tcdm_wen(tcdm_wen),
    .tcdm_be(tcdm_be), .tcdm_data(tcdm_data), .tcdm_r_data(tcdm_r_data),
    .tcdm_r_valid(tcdm_r_valid), .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_add(mem_add),
    .mem_wen(mem_wen), .mem_be(mem_be), .mem_data(mem_data), .mem_r_data(mem_r_data),
    .mem_r_valid(mem_r_valid), .err_o(err_o), .perf_gnt_o(perf_gnt_o),
    .perf_stall_o(perf_stall_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int          rr = 0;
  int          outq[$];
  int          outcyc[$];
  int          cyc = 0;
  bit          err_m = 1'b0;
  logic [31:0] pg = 32'h0, ps = 32'h0;
  bit          hs_last;
  int          hs_w;

  // requester state
  logic [MP-1:0] pend = '0;
  logic [31:0]   p_add[MP], p_data[MP];
  logic          p_wen[MP];
  logic [3:0]    p_be[MP];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic set_req(input int p, input logic [31:0] a, input logic wen, input logic [3:0] be,
                         input logic [31:0] d);
    pend[p] = 1'b1; p_add[p] = a; p_wen[p] = wen; p_be[p] = be; p_data[p] = d;
  endtask

  task automatic check_and_advance();
    int w;
    bit any, full, hs, pop;
    logic [MP-1:0] eg, erv;
    #1;
    any  = |pend;
    full = (outq.size() == FD);
    w = -1;
    for (int k = 0; k < MP; k++) begin
      if (w < 0 && pend[(rr + k) % MP]) w = (rr + k) % MP;
    end
    hs  = rst_n && any && !full && mem_gnt;
    pop = rst_n && mem_r_valid && outq.size() != 0;
    eg  = '0;
    erv = '0;
    if (hs) eg[w] = 1'b1;
    if (pop) erv[outq[0]] = 1'b1;
    check_val("mem_req", mem_req, rst_n && any && !full);
    check_val("tcdm_gnt", tcdm_gnt, eg);
    if (rst_n && any) begin
      check_val("payload_ctl", {mem_be, mem_wen, mem_add}, {p_be[w], p_wen[w], p_add[w]});
      check_val("payload_data", mem_data, p_data[w]);
    end else begin
      check_val("payload_idle", {mem_be, mem_wen, mem_add, mem_data}, 64'h0);
    end
    check_val("r_valid", tcdm_r_valid, erv);
    for (int i = 0; i < MP; i++) check_val("r_data", tcdm_r_data[i], rst_n ? mem_r_data : 32'h0);
    check_val("err_o", err_o, err_m && rst_n);
`ifdef MUL_MDC_TCDM_ARB_PERF_EN
    check_val("perf_gnt", perf_gnt_o, rst_n ? pg : 32'h0);
    check_val("perf_stall", perf_stall_o, rst_n ? ps : 32'h0);
`else
    check_val("perf_gnt", perf_gnt_o, 32'h0);
    check_val("perf_stall", perf_stall_o, 32'h0);
`endif
    @(posedge clk);
    if (!rst_n) begin
      rr = 0; outq.delete(); outcyc.delete(); err_m = 1'b0; pg = 32'h0; ps = 32'h0;
      hs = 1'b0;
    end else begin
      if (mem_r_valid && outq.size() == 0) err_m = 1'b1;
      if (pop) begin
        void'(outq.pop_front());
        void'(outcyc.pop_front());
      end
      if (hs) begin
        outq.push_back(w);
        outcyc.push_back(cyc);
        rr = (w + 1) % MP;
        pg = pg + 32'h1;
      end
      if (any && !hs) ps = ps + 32'h1;
    end
    hs_last = hs;
    hs_w    = w;
    cyc++;
  endtask

  task automatic run_cycle(input bit gnt, input bit rv, input logic [31:0] rdata, input bit rstv);
    @(negedge clk);
    rst_n       = rstv;
    mem_gnt     = gnt;
    mem_r_valid = rv;
    mem_r_data  = rdata;
    tcdm_req    = pend;
    for (int i = 0; i < MP; i++) begin
      tcdm_add[i] = p_add[i]; tcdm_wen[i] = p_wen[i]; tcdm_be[i] = p_be[i]; tcdm_data[i] = p_data[i];
    end
    check_and_advance();
    if (hs_last) pend[hs_w] = 1'b0;
  endtask

  function automatic bit head_ready();
    return outq.size() != 0 && outcyc[0] < cyc;
  endfunction

  initial begin
    int gnt_p, rv_p;
    for (int i = 0; i < MP; i++) begin
      p_add[i] = 32'h0; p_wen[i] = 1'b0; p_be[i] = 4'h0; p_data[i] = 32'h0;
    end
    rst_n = 1'b0; mem_gnt = 1'b0; mem_r_valid = 1'b0; mem_r_data = 32'h0;
    tcdm_req = '0; tcdm_add = '0; tcdm_wen = '0; tcdm_be = '0; tcdm_data = '0;
    run_cycle(1'b0, 1'b0, 32'h0, 1'b0);
    run_cycle(1'b1, 1'b0, 32'h0, 1'b0);

    // single port read, one-cycle response
    set_req(2, 32'h100, 1'b1, 4'hF, 32'h0);
    run_cycle(1'b1, 1'b0, 32'h0, 1'b1);
    run_cycle(1'b1, 1'b1, 32'hDEADBEEF, 1'b1);

    // all ports requesting continuously with immediate responses
    for (int c = 0; c < 12; c++) begin
      for (int p = 0; p < MP; p++) if (!pend[p]) set_req(p, $urandom, 1'($urandom), 4'($urandom), $urandom);
      run_cycle(1'b1, head_ready(), $urandom, 1'b1);
    end

    // randomized phases sweeping grant and response rates
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) begin
        gnt_p = $urandom_range(20, 100);
        rv_p  = $urandom_range(0, 100);
      end
      for (int p = 0; p < MP; p++)
        if (!pend[p] && $urandom_range(0, 99) < 40) set_req(p, $urandom, 1'($urandom), 4'($urandom), $urandom);
      run_cycle($urandom_range(0, 99) < gnt_p, head_ready() && ($urandom_range(0, 99) < rv_p),
                $urandom, 1'b1);
    end

    // fill FIFO without responses, then reset mid-operation
    for (int c = 0; c < 8; c++) begin
      for (int p = 0; p < MP; p++) if (!pend[p]) set_req(p, $urandom, 1'($urandom), 4'($urandom), $urandom);
      run_cycle(1'b1, 1'b0, $urandom, 1'b1);
    end
    run_cycle(1'b1, 1'b0, 32'h0, 1'b0);
    pend = '0;
    set_req(3, 32'h300, 1'b0, 4'h3, 32'h12345678);
    run_cycle(1'b1, 1'b0, 32'h0, 1'b1);
    run_cycle(1'b0, 1'b1, 32'hCAFEF00D, 1'b1);

    // response with empty FIFO: dropped and err_o sticks until reset
    run_cycle(1'b0, 1'b1, 32'h55AA55AA, 1'b1);
    for (int c = 0; c < 4; c++) run_cycle(1'b0, 1'b0, $urandom, 1'b1);
    run_cycle(1'b0, 1'b0, 32'h0, 1'b0);
    run_cycle(1'b0, 1'b0, 32'h0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mul_mdc_tcdm_arbiter.md
Name: mul_mdc_tcdm_arbiter

Overview:
- Sits directly downstream of the mul_mdc accelerator top wrapper.
- Consumes its MP flat TCDM master ports and merges them onto one TCDM bank port using round-robin arbitration.
- Tracks outstanding transactions in an in-order index FIFO and routes each memory response back to the originating port.
- Used when the cluster exposes fewer TCDM bank ports than the accelerator has master ports.

Parameters:
- MP, 4, number of accelerator-side TCDM ports (2..16).
- FIFO_DEPTH, 4, maximum outstanding granted transactions (power of two, >=2).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset: one clock, synchronous, active-low
- tcdm_req  in  MP  per-port request from the accelerator
- tcdm_gnt  out  MP  per-port grant
- tcdm_add  in  MPx32  per-port address
- tcdm_wen  in  MP  per-port write-enable (1 = read, 0 = write)
- tcdm_be  in  MPx4  per-port byte enable
- tcdm_data  in  MPx32  per-port write data
- tcdm_r_data  out  MPx32  per-port read data
- tcdm_r_valid  out  MP  per-port response valid
- mem_req  out  1  bank request
- mem_gnt  in  1  bank grant
- mem_add  out  32  bank address
- mem_wen  out  1  bank write-enable
- mem_be  out  4  bank byte enable
- mem_data  out  32  bank write data
- mem_r_data  in  32  bank read data
- mem_r_valid  in  1  bank response valid
- err_o  out  1  sticky error: response received with FIFO empty
- perf_gnt_o  out  32  granted-transaction count (optional feature)
- perf_stall_o  out  32  stall-cycle count (optional feature)

Behaviour:
- Reset (rst_ni low at a clock edge) clears the following state:
  - rr_q = 0; FIFO empty (count 0, read and write pointers 0); err_o = 0; perf counters = 0.
  - All outputs are driven 0 during reset.
- Arbitration (combinational):
  - Winner w = first asserted tcdm_req index scanning rr_q, rr_q+1, ... modulo MP.
  - mem_req = (|tcdm_req) & (count != FIFO_DEPTH).
  - mem_add, mem_wen, mem_be and mem_data are muxed from port w; they are 0 when no request is present.
  - tcdm_gnt[w] = mem_gnt & mem_req. All other tcdm_gnt bits are 0.
  - Grant latency is zero cycles; it follows mem_gnt within the same cycle.
- Handshake = mem_req & mem_gnt. On a handshake:
  - rr_q <= (w+1) mod MP.
  - w is pushed into the FIFO.
  - rr_q does not change without a handshake.
- Every handshake, read or write, yields exactly one mem_r_valid in a later cycle (>=1 cycle after gnt). Responses are in order.
- Response routing:
  - On mem_r_valid with count != 0: pop head h; tcdm_r_valid[h] = 1 in the same cycle.
  - tcdm_r_data[i] = mem_r_data for every i (broadcast); only r_valid is routed.
- Simultaneous push and pop in one cycle: count is unchanged and both pointers advance.
- Full FIFO: mem_req is held 0 even if a pop occurs in the same cycle (no bypass). The request is re-offered the next cycle.
- Empty FIFO with mem_r_valid: the response is dropped, all tcdm_r_valid bits are 0, and err_o is set to 1 until reset.
- Requesters must hold req and payload stable until granted; the block does not register the payload.
- Reset mid-operation discards outstanding entries. Responses arriving after reset set err_o.
- Pointer wrap-around: pointers are log2(FIFO_DEPTH) bits wide. count is log2(FIFO_DEPTH)+1 bits wide.

Optional Feature:
- MUL_MDC_TCDM_ARB_PERF_EN defined:
  - perf_gnt_o increments on each handshake.
  - perf_stall_o increments each cycle with |tcdm_req and no handshake.
  - Both counters are 32-bit, wrap at 2^32-1 to 0, and reset to 0.
- Macro undefined: perf_gnt_o and perf_stall_o are tied to 0 and no counter flops are instantiated.

Test Plan:
- Single port: MP=4, port 2 read at 0x100, mem_gnt=1, mem_r_valid one cycle later with data 0xDEADBEEF -> tcdm_gnt=0100, then tcdm_r_valid=0100 with r_data 0xDEADBEEF; err_o stays 0.
- Round-robin: all 4 ports request continuously, mem_gnt=1, 1-cycle responses -> grant order 0,1,2,3,0 and responses routed 0,1,2,3,0.
- Backpressure / full: FIFO_DEPTH=4, mem_gnt=1, responses withheld -> 4 handshakes, then mem_req=0 and perf_stall_o increments; one response -> mem_req reasserts the next cycle, not the same cycle.
- Concurrent push and pop: steady stream with count=2 -> count stays 2 for 10 cycles and all responses are routed correctly.
- Protocol error: mem_r_valid pulse with FIFO empty -> tcdm_r_valid=0000 and err_o=1 held until rst_ni low, then err_o=0.
- Mid-operation reset: 3 outstanding transactions, rst_ni low for 1 cycle -> count=0, rr_q=0, and a new request from port 3 is granted the next cycle.
